// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream write-port arbiter.
package axis_arb_pkg;

  // Arbiter FSM: waiting for a contest, or forwarding the granted packet.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  // Widest requester vector supported by onehot_to_idx.
  localparam int MAX_REQ = 16;

  // Converts a one-hot vector to its bit index. OR-reduction keeps it
  // free of priority logic; a zero vector maps to index 0.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: searches ptr+1, ptr+2, ... wrapping, and
// returns the first requesting index both one-hot and binary.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic             found;
  int               j;
  logic [IDX_W-1:0] jj;

  // Walk the ring starting just after the last winner; first hit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        found       = 1'b1;
        win_oh[jj]  = 1'b1;
        win_idx     = jj;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_mem_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream write port among
// NUM_REQ requesters, with a single output register stage.
//
// Handshake: a beat moves across an interface on a rising edge where both
// tvalid and tready are 1. The arbiter never makes tready depend on the
// requester's own tvalid; the output register accepts a new beat whenever
// it is empty or is being drained in the same cycle.
module axis_mem_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                            axis_aclk,
  input  logic                            axis_aresetn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_REQ-1:0]              s_axis_tvalid,
  input  logic [NUM_REQ-1:0]              s_axis_tlast,
  output logic [NUM_REQ-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]         m01_axis_tstrb,
  output logic                            m01_axis_tvalid,
  output logic                            m01_axis_tlast,
  input  logic                            m01_axis_tready,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            err_trunc,
  output logic                            dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);

  arb_state_t          state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    beat_cnt;

  logic [NUM_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                any_req;

  logic [IDX_W-1:0]    g;
  logic                out_free;
  logic                accept;
  logic                last_beat;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_W-1:0]   sel_strb;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any_req)
  );

  assign g         = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));
  assign out_free  = !m01_axis_tvalid || m01_axis_tready;
  assign accept    = (state == ARB_XFER) && s_axis_tvalid[g] && out_free;
  assign last_beat = s_axis_tlast[g] || (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign s_axis_tready = ((state == ARB_XFER) && out_free) ? grant : '0;
  assign dbg_state = state;

  // AND-OR data mux driven directly by the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb = sel_strb | s_axis_tstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Arbitration FSM: grant, round-robin pointer, beat counter, truncation flag.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      beat_cnt  <= '0;
      err_trunc <= 1'b0;
    end else begin
      err_trunc <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant  <= win_oh;
            rr_ptr <= win_idx;
            state  <= ARB_XFER;
          end else begin
            grant  <= '0;
          end
        end
        ARB_XFER: begin
          if (accept) begin
            if (last_beat) begin
              grant     <= '0;
              beat_cnt  <= '0;
              state     <= ARB_IDLE;
              err_trunc <= !s_axis_tlast[g];
            end else begin
              beat_cnt  <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Output register: loads each accepted beat, holds while stalled,
  // empties once drained with nothing new behind it.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m01_axis_tdata  <= '0;
      m01_axis_tstrb  <= '0;
      m01_axis_tvalid <= 1'b0;
      m01_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m01_axis_tdata  <= sel_data;
      m01_axis_tstrb  <= sel_strb;
      m01_axis_tvalid <= 1'b1;
      m01_axis_tlast  <= last_beat;
    end else if (m01_axis_tready) begin
      m01_axis_tvalid <= 1'b0;
    end
  end

endmodule
